// File: rtl/mmu_pkg.sv
// Shared definitions for the page-table walker.
// Contents: satp mode encodings, PTE bit positions, walker FSM state type,
// and helpers that map a walk level to its superpage mask and to the PPN
// bits that must be zero for a leaf found at that level.
package mmu_pkg;

  localparam logic [3:0] SATP_MODE_SV32 = 4'd1;
  localparam logic [3:0] SATP_MODE_SV39 = 4'd8;

  localparam int PTE_BIT_V = 0;
  localparam int PTE_BIT_R = 1;
  localparam int PTE_BIT_W = 2;
  localparam int PTE_BIT_X = 3;
  localparam int PTE_BIT_A = 6;

  typedef enum logic [1:0] {
    PTW_IDLE = 2'd0,
    PTW_REQ  = 2'd1,
    PTW_WAIT = 2'd2,
    PTW_DONE = 2'd3
  } ptw_state_e;

  // Superpage mask reported to the TLB for a leaf found at this level.
  function automatic logic [2:0] lvl_to_spage(input logic [1:0] lvl);
    logic [2:0] s;
    case (lvl)
      2'd1:    s = 3'b001;
      2'd2:    s = 3'b011;
      default: s = 3'b000;
    endcase
    return s;
  endfunction

  // PPN bits that must be zero for a leaf at this level (superpage alignment).
  function automatic logic [43:0] superpage_mask(input logic [1:0] lvl, input logic sv32);
    logic [43:0] m;
    m = '0;
    if (sv32) begin
      if (lvl == 2'd1) m[9:0] = '1;
    end else begin
      case (lvl)
        2'd1:    m[8:0]  = '1;
        2'd2:    m[17:0] = '1;
        default: m       = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ptw_pte_decode.sv
// Combinational PTE classifier for the page-table walker.
// Ports:
//   pte_raw   in  64  PTE as read from memory (Sv32 PTE in [31:0])
//   lvl       in  2   level the PTE was fetched at
//   sv32      in  1   1 = Sv32 walk, 0 = Sv39 walk
//   rerr      in  1   bus error returned with this read
//   leaf      out 1   valid, well-formed, accessed and aligned leaf
//   descend   out 1   valid pointer with a lower level still available
//   pf / af   out 1   page fault / access fault (af wins, never both)
//   next_ppn  out 44  PPN field of the PTE (next table or leaf frame)
//   spage     out 3   superpage mask for a leaf at lvl
//   pte_eff   out 64  PTE with Sv32 upper half forced to zero
module ptw_pte_decode
  import mmu_pkg::*;
(
  input  logic [63:0] pte_raw,
  input  logic [1:0]  lvl,
  input  logic        sv32,
  input  logic        rerr,
  output logic        leaf,
  output logic        descend,
  output logic        pf,
  output logic        af,
  output logic [43:0] next_ppn,
  output logic [2:0]  spage,
  output logic [63:0] pte_eff
);

  logic v, r, w, x, a;
  logic is_leaf, bad_fmt, misalign, leaf_bad, ptr_bottom;

  assign pte_eff  = sv32 ? {32'b0, pte_raw[31:0]} : pte_raw;
  assign next_ppn = sv32 ? {22'b0, pte_eff[31:10]} : pte_eff[53:10];

  assign v = pte_eff[PTE_BIT_V];
  assign r = pte_eff[PTE_BIT_R];
  assign w = pte_eff[PTE_BIT_W];
  assign x = pte_eff[PTE_BIT_X];
  assign a = pte_eff[PTE_BIT_A];

  assign is_leaf = r | x;
  // Reserved upper bits only exist in the Sv39 format.
  assign bad_fmt = ~v | (w & ~r) | (~sv32 & (|pte_eff[63:54]));
  assign misalign = |(next_ppn & superpage_mask(lvl, sv32));
  assign leaf_bad = is_leaf & (~a | misalign);
  // A pointer at level 0 has nowhere left to go.
  assign ptr_bottom = ~is_leaf & (lvl == 2'd0);

  assign af      = rerr;
  assign pf      = ~rerr & (bad_fmt | leaf_bad | ptr_bottom);
  assign leaf    = ~rerr & ~bad_fmt & is_leaf & ~leaf_bad;
  assign descend = ~rerr & ~bad_fmt & ~is_leaf & (lvl != 2'd0);
  assign spage   = lvl_to_spage(lvl);

endmodule

// File: rtl/mmu_ptw.sv
// Sv32/Sv39 hardware page-table walker.
// Accepts a TLB-miss request, walks the page table one PTE read at a time
// over a single-outstanding memory port, fills the TLB on a good leaf and
// returns the result (or a page/access fault) to the MMU.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req_valid/req_ready         walk request handshake (ready only in IDLE
//                               and only for a supported satp mode)
//   req_vpn/satp_mode/satp_ppn  request payload
//   mem_req/mem_ready/mem_addr  PTE read request, held until accepted
//   mem_rvalid/rdata/rerr       PTE read return
//   tlb_flush_req               flush in progress: suppresses this walk's fill
//   tlb_we/vpn/spage/pte        TLB fill (one cycle)
//   rsp_valid/pf/af/pte/spage   walk result (one cycle)
// mem_addr is the 56-bit computed address truncated to PADDR_W (PADDR_W <= 56).
module mmu_ptw
  import mmu_pkg::*;
#(
  parameter int PADDR_W = 56,
  parameter int PTE_W   = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [26:0]        req_vpn,
  input  logic [3:0]         req_satp_mode,
  input  logic [43:0]        req_satp_ppn,
  output logic               mem_req,
  input  logic               mem_ready,
  output logic [PADDR_W-1:0] mem_addr,
  input  logic               mem_rvalid,
  input  logic [63:0]        mem_rdata,
  input  logic               mem_rerr,
  input  logic               tlb_flush_req,
  output logic               tlb_we,
  output logic [26:0]        tlb_vpn,
  output logic [2:0]         tlb_spage,
  output logic [PTE_W-1:0]   tlb_pte,
  output logic               rsp_valid,
  output logic               rsp_pf,
  output logic               rsp_af,
  output logic [PTE_W-1:0]   rsp_pte,
  output logic [2:0]         rsp_spage
);

  ptw_state_e state_q, state_d;

  logic [26:0] vpn_q;
  logic        sv32_q;
  logic [43:0] ppn_q;
  logic [1:0]  lvl_q;
  logic        kill_q;
  logic        pf_q, af_q;
  logic [63:0] pte_q;
  logic [2:0]  spage_q;

  logic        mode_ok, accept, in_done;
  logic [11:0] idx_off;
  logic [55:0] addr_full;

  logic        dec_leaf, dec_descend, dec_pf, dec_af;
  logic [43:0] dec_next_ppn;
  logic [2:0]  dec_spage;
  logic [63:0] dec_pte;

  assign mode_ok   = (req_satp_mode == SATP_MODE_SV32) | (req_satp_mode == SATP_MODE_SV39);
  assign req_ready = (state_q == PTW_IDLE) & mode_ok;
  assign accept    = req_valid & req_ready;

  ptw_pte_decode u_decode (
    .pte_raw  (mem_rdata),
    .lvl      (lvl_q),
    .sv32     (sv32_q),
    .rerr     (mem_rerr),
    .leaf     (dec_leaf),
    .descend  (dec_descend),
    .pf       (dec_pf),
    .af       (dec_af),
    .next_ppn (dec_next_ppn),
    .spage    (dec_spage),
    .pte_eff  (dec_pte)
  );

  // PTE byte offset inside the current table: index * PTE size.
  always_comb begin
    idx_off = '0;
    if (sv32_q) begin
      if (lvl_q == 2'd1) idx_off = {vpn_q[19:10], 2'b00};
      else               idx_off = {vpn_q[9:0], 2'b00};
    end else begin
      case (lvl_q)
        2'd2:    idx_off = {vpn_q[26:18], 3'b000};
        2'd1:    idx_off = {vpn_q[17:9], 3'b000};
        default: idx_off = {vpn_q[8:0], 3'b000};
      endcase
    end
  end

  assign addr_full = {ppn_q, 12'b0} + {44'b0, idx_off};

  always_comb begin
    state_d = state_q;
    case (state_q)
      PTW_IDLE: if (accept)     state_d = PTW_REQ;
      PTW_REQ:  if (mem_ready)  state_d = PTW_WAIT;
      PTW_WAIT: if (mem_rvalid) state_d = dec_descend ? PTW_REQ : PTW_DONE;
      PTW_DONE:                 state_d = PTW_IDLE;
      default:                  state_d = PTW_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PTW_IDLE;
      vpn_q   <= '0;
      sv32_q  <= 1'b0;
      ppn_q   <= '0;
      lvl_q   <= '0;
      kill_q  <= 1'b0;
      pf_q    <= 1'b0;
      af_q    <= 1'b0;
      pte_q   <= '0;
      spage_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        PTW_IDLE: begin
          if (accept) begin
            vpn_q  <= req_vpn;
            sv32_q <= (req_satp_mode == SATP_MODE_SV32);
            ppn_q  <= req_satp_ppn;
            lvl_q  <= (req_satp_mode == SATP_MODE_SV32) ? 2'd1 : 2'd2;
            kill_q <= tlb_flush_req;
          end
        end
        PTW_REQ: begin
          if (tlb_flush_req) kill_q <= 1'b1;
        end
        PTW_WAIT: begin
          if (tlb_flush_req) kill_q <= 1'b1;
          if (mem_rvalid) begin
            if (dec_descend) begin
              lvl_q <= lvl_q - 2'd1;
              ppn_q <= dec_next_ppn;
            end else begin
              pf_q    <= dec_pf;
              af_q    <= dec_af;
              pte_q   <= dec_leaf ? dec_pte : '0;
              spage_q <= dec_leaf ? dec_spage : '0;
            end
          end
        end
        PTW_DONE: begin
          kill_q <= 1'b0;
        end
        default: kill_q <= 1'b0;
      endcase
    end
  end

  // Outputs are gated to zero outside the states that own them.
  assign in_done  = (state_q == PTW_DONE);
  assign mem_req  = (state_q == PTW_REQ);
  assign mem_addr = mem_req ? addr_full[PADDR_W-1:0] : '0;

  assign rsp_valid = in_done;
  assign rsp_pf    = in_done & pf_q;
  assign rsp_af    = in_done & af_q;
  assign rsp_pte   = in_done ? pte_q[PTE_W-1:0] : '0;
  assign rsp_spage = in_done ? spage_q : '0;

  // A flush arriving in the DONE cycle itself still blocks the fill.
  assign tlb_we    = in_done & ~pf_q & ~af_q & ~kill_q & ~tlb_flush_req;
  assign tlb_vpn   = tlb_we ? vpn_q : '0;
  assign tlb_spage = tlb_we ? spage_q : '0;
  assign tlb_pte   = tlb_we ? pte_q[PTE_W-1:0] : '0;

endmodule

// File: tb/tb_mmu_ptw.sv
`timescale 1ns/1ps
module tb_mmu_ptw;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [26:0] req_vpn;
  logic [3:0]  req_satp_mode;
  logic [43:0] req_satp_ppn;
  logic        mem_req;
  logic        mem_ready;
  logic [55:0] mem_addr;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        mem_rerr;
  logic        tlb_flush_req;
  logic        tlb_we;
  logic [26:0] tlb_vpn;
  logic [2:0]  tlb_spage;
  logic [63:0] tlb_pte;
  logic        rsp_valid;
  logic        rsp_pf;
  logic        rsp_af;
  logic [63:0] rsp_pte;
  logic [2:0]  rsp_spage;

  always #5 clk = ~clk;

  mmu_ptw #(.PADDR_W(56), .PTE_W(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_vpn(req_vpn),
    .req_satp_mode(req_satp_mode), .req_satp_ppn(req_satp_ppn),
    .mem_req(mem_req), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rerr(mem_rerr),
    .tlb_flush_req(tlb_flush_req),
    .tlb_we(tlb_we), .tlb_vpn(tlb_vpn), .tlb_spage(tlb_spage), .tlb_pte(tlb_pte),
    .rsp_valid(rsp_valid), .rsp_pf(rsp_pf), .rsp_af(rsp_af),
    .rsp_pte(rsp_pte), .rsp_spage(rsp_spage)
  );

  typedef struct { logic [55:0] addr; logic [63:0] data; logic err; } mem_t;
  typedef struct { logic pf; logic af; logic [63:0] pte; logic [2:0] spage; } rsp_t;
  typedef struct { logic [26:0] vpn; logic [2:0] spage; logic [63:0] pte; } fill_t;

  mem_t  mem_q[$];
  rsp_t  rsp_q[$];
  fill_t fill_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int stall_req = 0;
  bit hold_rsp = 1'b0;
  bit late_inject = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_mem(input logic [55:0] addr, input logic [63:0] data, input logic err);
    mem_t e;
    e.addr = addr; e.data = data; e.err = err;
    mem_q.push_back(e);
  endtask

  task automatic add_rsp(input logic pf, input logic af, input logic [63:0] pte, input logic [2:0] spage);
    rsp_t e;
    e.pf = pf; e.af = af; e.pte = pte; e.spage = spage;
    rsp_q.push_back(e);
  endtask

  task automatic add_fill(input logic [26:0] vpn, input logic [2:0] spage, input logic [63:0] pte);
    fill_t e;
    e.vpn = vpn; e.spage = spage; e.pte = pte;
    fill_q.push_back(e);
  endtask

  // Memory responder: checks each PTE address against the expected read list,
  // optionally stalls mem_ready, returns data one cycle after acceptance.
  initial begin : responder
    logic        pending;
    logic [63:0] pdata;
    logic        perr;
    int          stalls;
    logic [55:0] first_addr;
    bit          seen;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rerr = 1'b0;
    pending = 1'b0; pdata = '0; perr = 1'b0; stalls = 0; first_addr = '0; seen = 1'b0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rerr = 1'b0; mem_rdata = '0; mem_ready = 1'b0;
      if (rst) begin
        pending = 1'b0; seen = 1'b0; stalls = 0;
      end else if (late_inject) begin
        mem_rvalid = 1'b1; mem_rdata = 64'h200000CF;
      end else if (pending) begin
        pending = 1'b0; mem_rvalid = 1'b1; mem_rdata = pdata; mem_rerr = perr;
      end else if (mem_req) begin
        if (!seen) begin
          seen = 1'b1; first_addr = mem_addr; stalls = 0;
        end else begin
          check("stall_addr_stable", 64'(mem_addr), 64'(first_addr));
        end
        if (stalls < stall_req) begin
          stalls++;
        end else begin
          mem_ready = 1'b1; seen = 1'b0;
          if (mem_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_mem_req: got addr 0x%0h expected no request", mem_addr);
            pdata = '0; perr = 1'b0;
          end else begin
            mem_t e;
            e = mem_q.pop_front();
            check("mem_addr", 64'(mem_addr), 64'(e.addr));
            pdata = e.data; perr = e.err;
          end
          pending = !hold_rsp;
        end
      end else if (seen) begin
        check("mem_req_held", 64'(mem_req), 64'd1);
        seen = 1'b0;
      end
    end
  end

  // Output monitor: pops the scoreboard whenever the DUT presents a result or a fill.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rsp: got pf=%0b af=%0b pte=0x%0h expected none", rsp_pf, rsp_af, rsp_pte);
        end else begin
          rsp_t e;
          e = rsp_q.pop_front();
          check("rsp_pf", 64'(rsp_pf), 64'(e.pf));
          check("rsp_af", 64'(rsp_af), 64'(e.af));
          check("rsp_pte", rsp_pte, e.pte);
          check("rsp_spage", 64'(rsp_spage), 64'(e.spage));
        end
      end
      if (tlb_we) begin
        if (fill_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_tlb_we: got vpn=0x%0h pte=0x%0h expected no fill", tlb_vpn, tlb_pte);
        end else begin
          fill_t f;
          f = fill_q.pop_front();
          check("tlb_vpn", 64'(tlb_vpn), 64'(f.vpn));
          check("tlb_spage", 64'(tlb_spage), 64'(f.spage));
          check("tlb_pte", tlb_pte, f.pte);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [26:0] vpn, input logic [3:0] mode, input logic [43:0] ppn);
    int t;
    t = 0;
    req_vpn = vpn; req_satp_mode = mode; req_satp_ppn = ppn; req_valid = 1'b1;
    while (!req_ready && t < 50) begin tick(); t++; end
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((rsp_q.size() != 0 || mem_q.size() != 0) && t < 300) begin tick(); t++; end
    tick(); tick();
    check({name, "_rsp_left"}, 64'(rsp_q.size()), 64'd0);
    check({name, "_mem_left"}, 64'(mem_q.size()), 64'd0);
    check({name, "_fill_left"}, 64'(fill_q.size()), 64'd0);
  endtask

  task automatic wait_mem_taken();
    int t;
    t = 0;
    while (mem_q.size() != 0 && t < 100) begin tick(); t++; end
    check("mem_taken", 64'(mem_q.size()), 64'd0);
  endtask

  initial begin : stim
    rst = 1'b1; req_valid = 1'b0; req_vpn = '0; req_satp_mode = 4'd1;
    req_satp_ppn = '0; tlb_flush_req = 1'b0;
    tick(); tick();
    check("reset_req_ready", 64'(req_ready), 64'd1);
    check("reset_mem_req", 64'(mem_req), 64'd0);
    check("reset_mem_addr", 64'(mem_addr), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_tlb_we", 64'(tlb_we), 64'd0);
    check("reset_rsp_pte", rsp_pte, 64'd0);
    rst = 1'b0;
    tick();

    req_satp_mode = 4'd0; #1;
    check("mode0_not_ready", 64'(req_ready), 64'd0);
    req_satp_mode = 4'd8; #1;
    check("mode8_ready", 64'(req_ready), 64'd1);
    req_satp_mode = 4'd1;
    tick();

    // Sv32 two-level 4K walk
    add_mem(56'h80000120, 64'h20000401, 1'b0);
    add_mem(56'h80001D14, 64'h200000CF, 1'b0);
    add_rsp(1'b0, 1'b0, 64'h200000CF, 3'b000);
    add_fill(27'h12345, 3'b000, 64'h200000CF);
    issue(27'h12345, 4'd1, 44'h80000);
    drain("sv32_4k");

    // Sv32 megapage, aligned
    add_mem(56'h80000120, 64'h200000CF, 1'b0);
    add_rsp(1'b0, 1'b0, 64'h200000CF, 3'b001);
    add_fill(27'h12345, 3'b001, 64'h200000CF);
    issue(27'h12345, 4'd1, 44'h80000);
    drain("sv32_mega");

    // Sv32 megapage, misaligned PPN
    add_mem(56'h80000120, 64'h200004CF, 1'b0);
    add_rsp(1'b1, 1'b0, 64'h0, 3'b000);
    issue(27'h12345, 4'd1, 44'h80000);
    drain("sv32_mega_misalign");

    // Sv39 gigapage
    add_mem(56'h80000240, 64'h100000CF, 1'b0);
    add_rsp(1'b0, 1'b0, 64'h100000CF, 3'b011);
    add_fill(27'h1234567, 3'b011, 64'h100000CF);
    issue(27'h1234567, 4'd8, 44'h80000);
    drain("sv39_giga");

    // Sv39 L2 pointer then invalid L1 PTE
    add_mem(56'h80000240, 64'h20000401, 1'b0);
    add_mem(56'h80001D10, 64'h0, 1'b0);
    add_rsp(1'b1, 1'b0, 64'h0, 3'b000);
    issue(27'h1234567, 4'd8, 44'h80000);
    drain("sv39_l1_invalid");

    // Sv39 pointer found at level 0
    add_mem(56'h80000240, 64'h20000401, 1'b0);
    add_mem(56'h80001D10, 64'h20000801, 1'b0);
    add_mem(56'h80002B38, 64'h20000C01, 1'b0);
    add_rsp(1'b1, 1'b0, 64'h0, 3'b000);
    issue(27'h1234567, 4'd8, 44'h80000);
    drain("sv39_l0_ptr");

    // Sv39 reserved upper bits set on an otherwise good leaf
    add_mem(56'h80000240, 64'h00400000100000CF, 1'b0);
    add_rsp(1'b1, 1'b0, 64'h0, 3'b000);
    issue(27'h1234567, 4'd8, 44'h80000);
    drain("sv39_reserved");

    // Bus error on second read
    add_mem(56'h80000120, 64'h20000401, 1'b0);
    add_mem(56'h80001D14, 64'h200000CF, 1'b1);
    add_rsp(1'b0, 1'b1, 64'h0, 3'b000);
    issue(27'h12345, 4'd1, 44'h80000);
    drain("rerr");

    // mem_ready stalled 5 cycles, flush pulse while waiting for data
    stall_req = 5;
    add_mem(56'h80000120, 64'h200000CF, 1'b0);
    add_rsp(1'b0, 1'b0, 64'h200000CF, 3'b001);
    issue(27'h12345, 4'd1, 44'h80000);
    wait_mem_taken();
    tlb_flush_req = 1'b1;
    tick();
    tlb_flush_req = 1'b0;
    drain("stall_flush");
    stall_req = 0;

    // Flush while idle has no effect on the next walk
    tlb_flush_req = 1'b1;
    tick();
    tlb_flush_req = 1'b0;
    add_mem(56'h80000120, 64'h20000401, 1'b0);
    add_mem(56'h80001D14, 64'h200000CF, 1'b0);
    add_rsp(1'b0, 1'b0, 64'h200000CF, 3'b000);
    add_fill(27'h12345, 3'b000, 64'h200000CF);
    issue(27'h12345, 4'd1, 44'h80000);
    drain("after_flush");

    // Reset while waiting for data, then a stale return after release
    hold_rsp = 1'b1;
    add_mem(56'h80000120, 64'h20000401, 1'b0);
    issue(27'h12345, 4'd1, 44'h80000);
    wait_mem_taken();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    hold_rsp = 1'b0;
    tick();
    late_inject = 1'b1;
    tick();
    late_inject = 1'b0;
    tick(); tick();
    check("late_req_ready", 64'(req_ready), 64'd1);
    check("late_mem_req", 64'(mem_req), 64'd0);
    check("late_rsp_valid", 64'(rsp_valid), 64'd0);
    check("late_tlb_we", 64'(tlb_we), 64'd0);
    check("late_rsp_pte", rsp_pte, 64'd0);
    drain("reset_walk");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
